uba_reg_if: RTL and testbench

UBA_REG_IF -- requirements
Module: uba_reg_if

---
 rtl/ubapkg.sv | 36 +++
 rtl/uba_addr_dec.sv | 42 ++++
 rtl/uba_reg_if.sv | 126 ++++++++++++
 tb/tb_uba_reg_if.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ubapkg.sv
// Shared definitions for the UBA register interface: FSM states, access targets,
// register window offsets and backplane address field positions.
package ubapkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_READ,
    ST_ACK,
    ST_HOLD
  } uba_state_t;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_PAGE,
    TGT_STAT,
    TGT_MAINT
  } uba_target_t;

  // Offsets from the UBA base address.
  localparam logic [17:0] UBA_PAGE_LO   = 18'o000;
  localparam logic [17:0] UBA_PAGE_HI   = 18'o077;
  localparam logic [17:0] UBA_STAT_OFS  = 18'o100;
  localparam logic [17:0] UBA_MAINT_OFS = 18'o101;

  // Bit positions within busADDRI[0:35] (bit 0 is the MSB).
  localparam int unsigned UBA_READ_BIT  = 3;
  localparam int unsigned UBA_WRITE_BIT = 5;
  localparam int unsigned UBA_IO_BIT    = 6;
  localparam int unsigned UBA_DEV_MSB   = 14;
  localparam int unsigned UBA_DEV_LSB   = 17;
  localparam int unsigned UBA_REG_MSB   = 18;
  localparam int unsigned UBA_REG_LSB   = 35;
  localparam int unsigned UBA_PAGE_MSB  = 30;

endpackage

// File: rtl/uba_addr_dec.sv
// Combinational decode of a backplane address into a UBA register hit,
// the addressed register class, and the page RAM index.
module uba_addr_dec
  import ubapkg::*;
#(
  parameter logic [3:0]  ubaNUM  = 4'd1,
  parameter logic [17:0] ubaBASE = 18'o763000
) (
  input  logic [0:35]  addr,
  output logic         hit,
  output uba_target_t  target,
  output logic [0:5]   page_addr
);

  logic [17:0] reg_addr;
  logic [17:0] offset;
  logic [3:0]  dev;
  logic        unused_bits;

  assign reg_addr    = addr[UBA_REG_MSB:UBA_REG_LSB];
  assign offset      = reg_addr - ubaBASE;
  assign dev         = addr[UBA_DEV_MSB:UBA_DEV_LSB];
  assign page_addr   = addr[UBA_PAGE_MSB:UBA_REG_LSB];
  assign unused_bits = ^{addr[0:5], addr[7:13]};

  // The lower-bound test guards against the subtraction wrapping for addresses below the base.
  always_comb begin
    target = TGT_NONE;
    if (reg_addr >= ubaBASE) begin
      if (offset >= UBA_PAGE_LO && offset <= UBA_PAGE_HI) begin
        target = TGT_PAGE;
      end else if (offset == UBA_STAT_OFS) begin
        target = TGT_STAT;
      end else if (offset == UBA_MAINT_OFS) begin
        target = TGT_MAINT;
      end
    end
  end

  assign hit = addr[UBA_IO_BIT] && (dev == ubaNUM) && (target != TGT_NONE);

endmodule

// File: rtl/uba_reg_if.sv
// UBA register window slave: decodes backplane IO requests into one-cycle
// page/status/maintenance strobes and returns a single acknowledge.
module uba_reg_if
  import ubapkg::*;
#(
  parameter logic [3:0]  ubaNUM  = 4'd1,
  parameter logic [17:0] ubaBASE = 18'o763000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busREQI,
  input  logic [0:35] busADDRI,
  output logic        busACKO,
  output logic [0:35] busDATAO,
  input  logic [0:35] pageDATA,
  input  logic [0:35] statDATA,
  output logic [0:5]  pageADDR,
  output logic        pageREAD,
  output logic        pageWRITE,
  output logic        statWRITE,
  output logic        maintWRITE
);

  // Handshake: the master holds busREQI high until it sees the one-cycle busACKO;
  // the slave acknowledges a request once and then waits in HOLD for busREQI to
  // fall before it will accept anything new. Misses are never acknowledged.

  uba_state_t  state;
  logic        lat_read;
  logic        lat_write;
  uba_target_t lat_tgt;

  logic        dec_hit;
  uba_target_t dec_tgt;
  logic [0:5]  dec_page;
  logic        req_read;
  logic        req_write;

  assign req_read  = busADDRI[UBA_READ_BIT];
  assign req_write = busADDRI[UBA_WRITE_BIT];

  uba_addr_dec #(
    .ubaNUM  (ubaNUM),
    .ubaBASE (ubaBASE)
  ) u_dec (
    .addr      (busADDRI),
    .hit       (dec_hit),
    .target    (dec_tgt),
    .page_addr (dec_page)
  );

  // Strobes are issued on the accept edge so they are visible in the DECODE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_HOLD;
      busACKO    <= 1'b0;
      busDATAO   <= '0;
      pageADDR   <= '0;
      pageREAD   <= 1'b0;
      pageWRITE  <= 1'b0;
      statWRITE  <= 1'b0;
      maintWRITE <= 1'b0;
      lat_read   <= 1'b0;
      lat_write  <= 1'b0;
      lat_tgt    <= TGT_NONE;
    end else begin
      busACKO    <= 1'b0;
      busDATAO   <= '0;
      pageREAD   <= 1'b0;
      pageWRITE  <= 1'b0;
      statWRITE  <= 1'b0;
      maintWRITE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (busREQI && dec_hit) begin
            state     <= ST_DECODE;
            lat_read  <= req_read;
            lat_write <= req_write;
            lat_tgt   <= dec_tgt;
            if (dec_tgt == TGT_PAGE) begin
              pageADDR <= dec_page;
            end
            if (req_read) begin
              pageREAD <= (dec_tgt == TGT_PAGE);
            end else if (req_write) begin
              pageWRITE  <= (dec_tgt == TGT_PAGE);
              statWRITE  <= (dec_tgt == TGT_STAT);
              maintWRITE <= (dec_tgt == TGT_MAINT);
            end
          end
        end
        ST_DECODE: begin
          if (lat_read) begin
            state <= ST_READ;
          end else if (lat_write) begin
            busACKO <= 1'b1;
            state   <= ST_ACK;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_READ: begin
          busACKO <= 1'b1;
          case (lat_tgt)
            TGT_PAGE: busDATAO <= pageDATA;
            TGT_STAT: busDATAO <= statDATA;
            default:  busDATAO <= '0;
          endcase
          state <= ST_ACK;
        end
        ST_ACK: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!busREQI) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uba_reg_if.sv
// Directed bench for uba_reg_if: read data is scoreboarded at each acknowledge,
// strobes and ACK timing are checked cycle by cycle inside each transfer.
module tb_uba_reg_if;
  import ubapkg::*;

  localparam logic [35:0] JUNK = 36'o555555555555;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busREQI = 1'b0;
  logic [0:35] busADDRI = '0;
  logic        busACKO;
  logic [0:35] busDATAO;
  logic [0:35] pageDATA = JUNK;
  logic [0:35] statDATA = 36'o777;
  logic [0:5]  pageADDR;
  logic        pageREAD;
  logic        pageWRITE;
  logic        statWRITE;
  logic        maintWRITE;

  logic [35:0] exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          ack_seen = 0;
  int          exp_acks = 0;
  bit          mon_en = 1'b0;

  uba_reg_if dut (
    .clk        (clk),
    .rst        (rst),
    .busREQI    (busREQI),
    .busADDRI   (busADDRI),
    .busACKO    (busACKO),
    .busDATAO   (busDATAO),
    .pageDATA   (pageDATA),
    .statDATA   (statDATA),
    .pageADDR   (pageADDR),
    .pageREAD   (pageREAD),
    .pageWRITE  (pageWRITE),
    .statWRITE  (statWRITE),
    .maintWRITE (maintWRITE)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
  endtask

  function automatic logic [0:35] mk_addr(input logic rd, input logic wr, input logic io,
                                          input logic [3:0] dev, input logic [17:0] ra);
    logic [0:35] a;
    a        = '0;
    a[3]     = rd;
    a[5]     = wr;
    a[6]     = io;
    a[14:17] = dev;
    a[18:35] = ra;
    return a;
  endfunction

  // scoreboard: every acknowledge pops one expected data word
  always @(negedge clk) begin
    if (mon_en) begin
      if (busACKO === 1'b1) begin
        ack_seen++;
        if (exp_q.size() != 0) chk("ack_data", busDATAO, exp_q.pop_front());
      end else begin
        chk("bus_zero", busDATAO, 36'd0);
      end
    end
  end

  // driver: raise a request, check strobes {pR,pW,sW,mW} and ACK each cycle
  task automatic do_xfer(input string tag, input logic [0:35] a, input logic [35:0] pdata,
                         input logic [3:0] exp_strb, input int ack_cyc,
                         input logic [35:0] exp_data, input int drop_cyc);
    int n_cyc;
    n_cyc = ((drop_cyc > ack_cyc) ? drop_cyc : ack_cyc) + 2;
    if (ack_cyc > 0) begin
      exp_q.push_back(exp_data);
      exp_acks++;
    end
    busADDRI = a;
    busREQI  = 1'b1;
    pageDATA = JUNK;
    for (int cyc = 1; cyc <= n_cyc; cyc++) begin
      @(negedge clk);
      chk({tag, "_strobes"}, 36'({pageREAD, pageWRITE, statWRITE, maintWRITE}),
          (cyc == 1) ? 36'(exp_strb) : 36'd0);
      chk({tag, "_ack"}, 36'(busACKO), 36'(cyc == ack_cyc));
      pageDATA = (cyc == 2) ? pdata : JUNK;
      if (cyc == ack_cyc) busADDRI = mk_addr(1'b0, 1'b1, 1'b1, 4'd1, 18'o763001);
      if (cyc == drop_cyc) begin
        busREQI  = 1'b0;
        busADDRI = JUNK;
      end
    end
    chk({tag, "_end_state"}, 36'(dut.state), 36'(ST_IDLE));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_ack", 36'(busACKO), 36'd0);
    chk("rst_strobes", 36'({pageREAD, pageWRITE, statWRITE, maintWRITE}), 36'd0);
    chk("rst_page_addr", 36'(pageADDR), 36'd0);
    chk("rst_state", 36'(dut.state), 36'(ST_HOLD));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_state", 36'(dut.state), 36'(ST_IDLE));

    do_xfer("mwr", mk_addr(1'b0, 1'b1, 1'b1, 4'd1, 18'o763101), JUNK, 4'b0001, 2, 36'd0, 2);
    do_xfer("prd", mk_addr(1'b1, 1'b0, 1'b1, 4'd1, 18'o763005), 36'o123456701234,
            4'b1000, 3, 36'o123456701234, 3);
    chk("prd_page_addr", 36'(pageADDR), 36'o05);

    do_xfer("miss_dev", mk_addr(1'b0, 1'b1, 1'b1, 4'd3, 18'o763100), JUNK, 4'b0000, 0, 36'd0, 20);
    do_xfer("miss_reg", mk_addr(1'b1, 1'b0, 1'b1, 4'd1, 18'o763102), JUNK, 4'b0000, 0, 36'd0, 20);
    do_xfer("miss_io", mk_addr(1'b0, 1'b1, 1'b0, 4'd1, 18'o763000), JUNK, 4'b0000, 0, 36'd0, 5);
    do_xfer("miss_below", mk_addr(1'b0, 1'b1, 1'b1, 4'd1, 18'o762777), JUNK, 4'b0000, 0, 36'd0, 5);
    chk("miss_page_addr", 36'(pageADDR), 36'o05);

    do_xfer("pwr_top", mk_addr(1'b0, 1'b1, 1'b1, 4'd1, 18'o763077), JUNK, 4'b0100, 2, 36'd0, 2);
    chk("pwr_top_page_addr", 36'(pageADDR), 36'o77);

    do_xfer("srd_hold", mk_addr(1'b1, 1'b0, 1'b1, 4'd1, 18'o763100), JUNK, 4'b0000, 3, 36'o777, 10);
    do_xfer("both_flags", mk_addr(1'b1, 1'b1, 1'b1, 4'd1, 18'o763100), JUNK, 4'b0000, 3, 36'o777, 3);
    do_xfer("mrd", mk_addr(1'b1, 1'b0, 1'b1, 4'd1, 18'o763101), JUNK, 4'b0000, 3, 36'd0, 3);
    chk("stat_page_addr", 36'(pageADDR), 36'o77);
    do_xfer("early_drop", mk_addr(1'b1, 1'b0, 1'b1, 4'd1, 18'o763040), 36'o1111,
            4'b1000, 3, 36'o1111, 1);
    chk("early_page_addr", 36'(pageADDR), 36'o40);
    do_xfer("no_flags", mk_addr(1'b0, 1'b0, 1'b1, 4'd1, 18'o763100), JUNK, 4'b0000, 0, 36'd0, 1);

    // reset in the middle of a status write with the request still held
    busADDRI = mk_addr(1'b0, 1'b1, 1'b1, 4'd1, 18'o763100);
    busREQI  = 1'b1;
    @(negedge clk);
    chk("rstx_strobe_n1", 36'(statWRITE), 36'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstx_statwrite", 36'(statWRITE), 36'd0);
    chk("rstx_ack", 36'(busACKO), 36'd0);
    chk("rstx_state", 36'(dut.state), 36'(ST_HOLD));
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstx_held_strobes", 36'({pageREAD, pageWRITE, statWRITE, maintWRITE}), 36'd0);
      chk("rstx_held_ack", 36'(busACKO), 36'd0);
    end
    busREQI = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstx_idle", 36'(dut.state), 36'(ST_IDLE));
    do_xfer("swr_after_rst", mk_addr(1'b0, 1'b1, 1'b1, 4'd1, 18'o763100), JUNK,
            4'b0010, 2, 36'd0, 2);

    repeat (3) @(negedge clk);
    chk("ack_total", 36'(ack_seen), 36'(exp_acks));
    chk("queue_empty", 36'(exp_q.size()), 36'd0);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
